spi_adc_serf: RTL and testbench
===============================

SPI_ADC_SERF -- requirements
Module: spi_adc_serf

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  input  1  system clock; all flops on its rising edge.
- rst  input  1  synchronous active-high reset.
- SS_n  input  1  serf select from the SPI master; asynchronous to clk; idle high.
- SCLK  input  1  SPI clock from the master; asynchronous to clk; idle high.
- MOSI  input  1  command data from the master.
- MISO  output  1  conversion data to the master.
- sample_in  input  12  conversion value for the channel on chnl_sel, supplied by the environment.
- chnl_sel  output  3  channel from the last complete command, cmd[13:11].
- cmd  output  16  last complete 16-bit command received.
- rdy  output  1  one-clk pulse when a complete 16-bit transaction ends.
- err  output  1  one-clk pulse when a transaction ends with fewer than 16 SCLK rises.

Function
REQ-003 SS_n, SCLK and MOSI SHALL each pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized signals with one further flop.
REQ-004 The SPI mode SHALL be CPOL=1/CPHA=1: MOSI is sampled on the SCLK rise, and MISO changes on the SCLK fall.
REQ-005 Correct operation SHALL be required only for SCLK high and low phases of 4 clk or more each.
REQ-006 The FSM SHALL have three states: ARM, IDLE and SHIFT. The reset state is ARM.
REQ-007 ARM SHALL go to IDLE when synchronized SS_n is high.
REQ-008 IDLE SHALL go to SHIFT on a synchronized SS_n fall.
REQ-009 SHIFT SHALL go to IDLE on a synchronized SS_n rise.
REQ-010 On entry to SHIFT, tx_shft[15:0] SHALL load {4'h0, sample_in}; later sample_in changes SHALL NOT affect the word being sent.
REQ-011 MISO SHALL equal tx_shft[15] while in SHIFT and 0 otherwise.
REQ-012 The first SCLK fall in a transaction SHALL NOT shift tx_shft; each later fall SHALL shift it left, filling with 0.
REQ-013 Each SCLK rise in SHIFT SHALL shift synchronized MOSI into the LSB of rx_shft[15:0] and increment a 5-bit rise counter, which is cleared on entry to SHIFT.
REQ-014 Once the counter reaches 16, further SCLK edges SHALL be ignored until SS_n rises.
REQ-015 On an SS_n rise with counter == 16, the block SHALL set cmd <= rx_shft and chnl_sel <= rx_shft[13:11], and pulse rdy for exactly 1 clk.
REQ-016 rdy SHALL assert on the 4th clk rising edge after SS_n rises at the port.
REQ-017 On an SS_n rise with counter < 16 (including 0), err SHALL pulse for 1 clk, with no rdy and cmd and chnl_sel unchanged.
REQ-018 rdy and err SHALL never be high in the same cycle.
REQ-019 SCLK activity while SS_n is high SHALL be ignored.
REQ-020 Reset mid-transaction SHALL abandon the transaction, and no new transaction SHALL start until SS_n has been seen high (ARM), even if SS_n stays low.

Reset
REQ-021 While rst=1, the block SHALL set MISO=0, cmd=16'h0000, chnl_sel=3'b000, rdy=0, err=0, tx_shft=0, rx_shft=0, counter=0 and state=ARM; synchronizers SHALL reset to 1 for SS_n and SCLK and 0 for MOSI.
REQ-022 Reset SHALL take priority over all other behaviour.

Verification
REQ-023 The bench SHALL cover these directed scenarios, with SCLK = clk/32 for all of them:
- Reset, SS_n/SCLK held high for 50 clk -> MISO=0, rdy=0, err=0, cmd=0000, chnl_sel=0.
- Master sends 16'h0800 while sample_in=12'h123 -> master receives 16'h0123; rdy pulses once for 1 clk; cmd=0800; chnl_sel=1.
- Next transaction with sample_in=12'hABC applied before the SS_n fall and changed to 12'h555 mid-word -> master receives 16'h0ABC.
- SS_n raised after 8 SCLK rises -> err pulses 1 clk, no rdy, cmd and chnl_sel keep their prior values; the next full transaction succeeds.
- rst pulsed after 5 rises with SS_n held low and SCLK toggling -> no rdy or err; after SS_n goes high, a new transaction sending 16'h3800 gives cmd=3800 and chnl_sel=7.
- Master sends 16'hFFFF with 2 extra SCLK cycles before SS_n rises -> cmd=FFFF, a single rdy pulse, no err.

Source files
------------

// File: rtl/spi_adc_serf.sv
// SPI serf (CPOL=1/CPHA=1) for an ADC front end: receives a 16-bit command on MOSI
// while returning the sampled 12-bit conversion value on MISO.
module spi_adc_serf (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [11:0] sample_in,
  output logic [2:0]  chnl_sel,
  output logic [15:0] cmd,
  output logic        rdy,
  output logic        err
);

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 5;
  localparam int unsigned AW = 2;

  typedef enum logic [1:0] {ARM, IDLE, SHIFT} state_t;

  state_t          r_state;
  logic            r_ss_s1, r_ss_s2, r_ss_d;
  logic            r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic            r_mosi_s1, r_mosi_s2;
  logic [DW-1:0]   r_tx;
  logic [DW-1:0]   r_rx;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_arm_cnt;
  logic            r_first;
  logic            r_end;
  logic            r_end_ok;

  logic w_ss_fall, w_ss_rise, w_sclk_rise, w_sclk_fall, w_cnt_full;

  // Two-flop synchronizers plus one edge-detect flop per asynchronous input
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ss_s1   <= 1'b1;
      r_ss_s2   <= 1'b1;
      r_ss_d    <= 1'b1;
      r_sclk_s1 <= 1'b1;
      r_sclk_s2 <= 1'b1;
      r_sclk_d  <= 1'b1;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_ss_s1   <= SS_n;
      r_ss_s2   <= r_ss_s1;
      r_ss_d    <= r_ss_s2;
      r_sclk_s1 <= SCLK;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_mosi_s1 <= MOSI;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  assign w_ss_fall   = r_ss_d & ~r_ss_s2;
  assign w_ss_rise   = r_ss_s2 & ~r_ss_d;
  assign w_sclk_fall = r_sclk_d & ~r_sclk_s2;
  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
  assign w_cnt_full  = (r_cnt == CW'(DW));

  // Transaction FSM; MISO is kept equal to tx[15] in SHIFT and 0 elsewhere.
  // End-of-transaction is staged through r_end so rdy/err land 4 clk after SS_n rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ARM;
      r_tx      <= '0;
      r_rx      <= '0;
      r_cnt     <= '0;
      r_arm_cnt <= '0;
      r_first   <= 1'b0;
      r_end     <= 1'b0;
      r_end_ok  <= 1'b0;
      MISO      <= 1'b0;
      cmd       <= '0;
      chnl_sel  <= '0;
      rdy       <= 1'b0;
      err       <= 1'b0;
    end else begin
      rdy   <= 1'b0;
      err   <= 1'b0;
      r_end <= 1'b0;
      if (r_end) begin
        if (r_end_ok) begin
          rdy      <= 1'b1;
          cmd      <= r_rx;
          chnl_sel <= r_rx[13:11];
        end else begin
          err <= 1'b1;
        end
      end
      case (r_state)
        ARM: begin
          // Let the synchronizer flush its reset value before trusting SS_n high
          if (r_arm_cnt != AW'(2)) r_arm_cnt <= r_arm_cnt + AW'(1);
          else if (r_ss_s2)        r_state   <= IDLE;
        end
        IDLE: begin
          if (w_ss_fall) begin
            r_state <= SHIFT;
            r_tx    <= {4'h0, sample_in};
            r_cnt   <= '0;
            r_first <= 1'b1;
            MISO    <= 1'b0;
          end
        end
        SHIFT: begin
          if (w_ss_rise) begin
            r_state  <= IDLE;
            MISO     <= 1'b0;
            r_end    <= 1'b1;
            r_end_ok <= w_cnt_full;
          end else if (!w_cnt_full) begin
            if (w_sclk_rise) begin
              r_rx  <= {r_rx[DW-2:0], r_mosi_s2};
              r_cnt <= r_cnt + CW'(1);
            end else if (w_sclk_fall) begin
              if (r_first) begin
                r_first <= 1'b0;
              end else begin
                r_tx <= {r_tx[DW-2:0], 1'b0};
                MISO <= r_tx[DW-2];
              end
            end
          end
        end
        default: r_state <= ARM;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_adc_serf.sv
// Scoreboard bench for spi_adc_serf: a behavioural SPI master drives SCLK = clk/32,
// expected rdy/err outcomes are queued per transaction and matched against DUT pulses.
module tb_spi_adc_serf;

  localparam int unsigned HALF = 16;

  typedef struct packed {
    logic        ok;
    logic [15:0] cmd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        SS_n, SCLK, MOSI;
  logic        MISO;
  logic [11:0] sample_in;
  logic [2:0]  chnl_sel;
  logic [15:0] cmd;
  logic        rdy, err;

  exp_t        sb[$];
  logic [15:0] m_cmd;
  int          n_checks = 0;
  int          n_errors = 0;

  spi_adc_serf dut (
    .clk       (clk),
    .rst       (rst),
    .SS_n      (SS_n),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .sample_in (sample_in),
    .chnl_sel  (chnl_sel),
    .cmd       (cmd),
    .rdy       (rdy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Every rdy/err pulse must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rdy || err) begin
      chk("rdy_err_excl", 32'(rdy & err), 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 32'({rdy, err}), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("pulse_is_rdy", 32'(rdy), 32'(e.ok));
        chk("cmd", 32'(cmd), 32'(e.cmd));
        chk("chnl_sel", 32'(chnl_sel), 32'(e.cmd[13:11]));
      end
    end
  end

  // One SPI transaction; nrise may be short (error) or long (extra SCLK cycles)
  task automatic xfer(input logic [15:0] tx, input int nrise,
                      input logic [11:0] samp, input logic [11:0] samp_mid);
    logic [15:0] rx;
    exp_t        e;
    int          lat;
    rx = '0;
    sample_in = samp;
    SS_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nrise; i++) begin
      SCLK = 1'b0;
      MOSI = (i < 16) ? tx[15-i] : 1'b0;
      if (i == 8) sample_in = samp_mid;
      wait_clk(HALF);
      if (i < 16) rx = {rx[14:0], MISO};
      SCLK = 1'b1;
      wait_clk(HALF);
    end
    e.ok  = (nrise >= 16);
    e.cmd = e.ok ? tx : m_cmd;
    m_cmd = e.cmd;
    sb.push_back(e);
    SS_n = 1'b1;
    lat = 0;
    while (lat < 8 && !(rdy || err)) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("end_latency", 32'(lat), 32'd4);
    wait_clk(20);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("miso_idle", 32'(MISO), 32'd0);
    if (nrise >= 16) chk("miso_word", 32'(rx), 32'({4'h0, samp}));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0; sample_in = '0;
    m_cmd = '0;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(50);
    chk("rst_miso", 32'(MISO), 32'd0);
    chk("rst_rdy", 32'(rdy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cmd", 32'(cmd), 32'd0);
    chk("rst_chnl", 32'(chnl_sel), 32'd0);

    xfer(16'h0800, 16, 12'h123, 12'h123);
    xfer(16'h1000, 16, 12'hABC, 12'h555);
    xfer(16'h7FFF, 8, 12'h321, 12'h321);
    xfer(16'h2800, 16, 12'h0F0, 12'h0F0);

    // Reset in the middle of a word with SS_n held low and SCLK still toggling
    sample_in = 12'h777;
    SS_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 5; i++) begin
      SCLK = 1'b0; MOSI = 1'b1; wait_clk(HALF);
      SCLK = 1'b1; wait_clk(HALF);
    end
    SCLK = 1'b0;
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    m_cmd = '0;
    wait_clk(HALF - 3);
    SCLK = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_clk(HALF); SCLK = 1'b0;
      wait_clk(HALF); SCLK = 1'b1;
    end
    wait_clk(HALF);
    SS_n = 1'b1;
    wait_clk(40);
    chk("midrst_cmd", 32'(cmd), 32'd0);
    chk("midrst_chnl", 32'(chnl_sel), 32'd0);
    chk("midrst_sb", 32'(sb.size()), 32'd0);

    xfer(16'h3800, 16, 12'h456, 12'h456);
    chk("cmd_3800", 32'(cmd), 32'h3800);
    chk("chnl_7", 32'(chnl_sel), 32'd7);

    xfer(16'hFFFF, 18, 12'hFED, 12'hFED);
    chk("cmd_ffff", 32'(cmd), 32'hFFFF);

    wait_clk(20);
    chk("final_sb", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
